mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 141 ++++++++++++++
 tb/tb_mem_responder.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: byte-wide RAM slave on a 16-bit address bus.
// An accepted hit is held for WAIT cycles, then performs one read or write.
// A decode miss completes at once with err set. dbo, rdy and err are registered.
module mem_responder #(
  parameter int          AW   = 8,
  parameter logic [15:0] BASE = 16'h0000,
  parameter int          WAIT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] abi,
  input  logic [7:0]  dbi,
  input  logic        req,
  input  logic        we,
  output logic [7:0]  dbo,
  output logic        rdy,
  output logic        err,
  output logic        busy
);

  localparam int          DEPTH = 1 << AW;
  // The limit is 17 bits wide so that AW = 16 (a 64 KiB window) still compares correctly.
  localparam logic [16:0] LIMIT = 17'(DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Hit test. The offset is compared only after the lower bound has been
  // checked, so an address below BASE can never wrap into the window.
  function automatic logic decode_hit(input logic [15:0] a);
    logic [15:0] off;
    off = a - BASE;
    return (a >= BASE) && ({1'b0, off} < LIMIT);
  endfunction

  // RAM index of an address that is already known to be a hit.
  function automatic logic [AW-1:0] decode_index(input logic [15:0] a);
    logic [15:0] off;
    off = a - BASE;
    return off[AW-1:0];
  endfunction

  state_t        state, state_nxt;
  logic [3:0]    cnt, cnt_nxt;
  logic          hit;
  logic          accept;
  logic          finish;

  // Request snapshot. After acceptance the bus inputs are ignored, so the
  // access that is in flight uses only these registers.
  logic [AW-1:0] idx_l;
  logic [7:0]    dat_l;
  logic          we_l;

  logic [7:0]    ram [DEPTH];

  assign hit    = decode_hit(abi);
  assign accept = (state == IDLE) && req;
  assign finish = (state == BUSY) && (cnt == 4'd0);
  assign busy   = (state == BUSY);

  // Next-state logic. Only a hit enters BUSY; a miss is answered directly from IDLE.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (req && hit) begin
          state_nxt = BUSY;
          cnt_nxt   = 4'(WAIT);
        end
      end
      BUSY: begin
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // State and wait counter. Reset drops any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Capture address, data and direction when a hit is accepted.
  always_ff @(posedge clk) begin
    if (accept && hit) begin
      idx_l <= decode_index(abi);
      dat_l <= dbi;
      we_l  <= we;
    end
  end

  // RAM write port. Its contents survive reset.
  always_ff @(posedge clk) begin
    if (finish && we_l) begin
      ram[idx_l] <= dat_l;
    end
  end

  // Completion outputs. rdy and err are single-cycle pulses; dbo changes only
  // on a read completion or a read miss.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy <= 1'b0;
      err <= 1'b0;
      dbo <= 8'h00;
    end else begin
      rdy <= 1'b0;
      err <= 1'b0;
      if (finish) begin
        rdy <= 1'b1;
        if (!we_l) begin
          dbo <= ram[idx_l];
        end
      end else if (accept && !hit) begin
        rdy <= 1'b1;
        err <= 1'b1;
        if (!we) begin
          dbo <= 8'hFF;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder. Two instances share one stimulus
// stream: instance 0 has WAIT=2 and instance 1 has WAIT=0. Both use AW=8 and
// BASE=16'h4000.
module tb_mem_responder;

  localparam int BASE_I = 'h4000;
  localparam int SPAN   = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] abi = 16'h0000;
  logic [7:0]  dbi = 8'h00;
  logic        req = 1'b0;
  logic        we  = 1'b0;

  logic [7:0]  dbo_w2, dbo_w0;
  logic        rdy_w2, rdy_w0, err_w2, err_w0, busy_w2, busy_w0;

  logic [7:0]  dbo_a  [2];
  logic        rdy_a  [2];
  logic        err_a  [2];
  logic        busy_a [2];

  assign dbo_a[0]  = dbo_w2;
  assign dbo_a[1]  = dbo_w0;
  assign rdy_a[0]  = rdy_w2;
  assign rdy_a[1]  = rdy_w0;
  assign err_a[0]  = err_w2;
  assign err_a[1]  = err_w0;
  assign busy_a[0] = busy_w2;
  assign busy_a[1] = busy_w0;

  mem_responder #(.AW(8), .BASE(16'h4000), .WAIT(2)) dut2 (
    .clk(clk), .rst(rst), .abi(abi), .dbi(dbi), .req(req), .we(we),
    .dbo(dbo_w2), .rdy(rdy_w2), .err(err_w2), .busy(busy_w2)
  );

  mem_responder #(.AW(8), .BASE(16'h4000), .WAIT(0)) dut0 (
    .clk(clk), .rst(rst), .abi(abi), .dbi(dbi), .req(req), .we(we),
    .dbo(dbo_w0), .rdy(rdy_w0), .err(err_w0), .busy(busy_w0)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         inst;
    int         cyc;
    logic       err;
    logic [7:0] dbo;
    bit         chk;
  } entry_t;

  entry_t sbq[$];

  int vec  = 0;
  int miss = 0;
  int edge_n = 0;

  // Reference model state, one copy per instance.
  logic [7:0] mem_m [2][SPAN];
  bit         mval  [2][SPAN];
  logic [7:0] mdbo  [2];
  bit         mdbo_k[2];
  int         free_at[2];
  int         bfrom [2];
  int         bto   [2];
  bit         pend  [2];
  int         pend_done[2];
  logic [7:0] pend_idx [2];
  logic [7:0] pend_dat [2];

  function automatic int wait_of(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  task automatic cmp8(input int i, input string nm, input logic [7:0] act, input logic [7:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s inst%0d edge %0d: got %h expected %h", nm, i, edge_n, act, exp);
    end
  endtask

  task automatic cmpi(input int i, input string nm, input int act, input int exp);
    vec++;
    if (act != exp) begin
      miss++;
      $display("FAIL %s inst%0d: got %0d expected %0d", nm, i, act, exp);
    end
  endtask

  // Reference-model update for one instance at the rising edge just taken.
  task automatic model_edge(input int i, input logic r, input logic [15:0] a,
                            input logic [7:0] d, input logic w);
    int         e;
    int         wt;
    int         ai;
    logic [7:0] ix;
    entry_t     en;
    e  = edge_n;
    wt = wait_of(i);
    ai = int'(a);
    if (pend[i] && pend_done[i] <= e) begin
      mem_m[i][pend_idx[i]] = pend_dat[i];
      mval[i][pend_idx[i]]  = 1'b1;
      pend[i] = 1'b0;
    end
    if (r && e >= free_at[i]) begin
      en.inst = i;
      if (ai >= BASE_I && ai < BASE_I + SPAN) begin
        ix     = 8'(ai - BASE_I);
        en.cyc = e + wt + 1;
        en.err = 1'b0;
        if (w) begin
          en.dbo       = mdbo[i];
          en.chk       = mdbo_k[i];
          pend[i]      = 1'b1;
          pend_idx[i]  = ix;
          pend_dat[i]  = d;
          pend_done[i] = e + wt + 1;
        end else begin
          en.dbo    = mem_m[i][ix];
          en.chk    = mval[i][ix];
          mdbo[i]   = en.dbo;
          mdbo_k[i] = en.chk;
        end
        bfrom[i]   = e;
        bto[i]     = e + wt;
        free_at[i] = e + wt + 2;
      end else begin
        en.cyc = e;
        en.err = 1'b1;
        if (w) begin
          en.dbo = mdbo[i];
          en.chk = mdbo_k[i];
        end else begin
          en.dbo    = 8'hFF;
          en.chk    = 1'b1;
          mdbo[i]   = 8'hFF;
          mdbo_k[i] = 1'b1;
        end
        free_at[i] = e + 1;
      end
      sbq.push_back(en);
    end
  endtask

  task automatic step(input logic r, input logic [15:0] a, input logic [7:0] d, input logic w);
    req = r; abi = a; dbi = d; we = w;
    @(posedge clk);
    edge_n++;
    for (int i = 0; i < 2; i++) model_edge(i, r, a, d, w);
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++)
      step(1'b0, 16'($urandom), 8'($urandom), 1'($urandom));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      cmp8(i, "rst_busy", {7'b0, busy_a[i]}, 8'h00);
      cmp8(i, "rst_rdy",  {7'b0, rdy_a[i]},  8'h00);
      cmp8(i, "rst_err",  {7'b0, err_a[i]},  8'h00);
      cmp8(i, "rst_dbo",  dbo_a[i],          8'h00);
      if (pend[i] && pend_done[i] <= edge_n) begin
        mem_m[i][pend_idx[i]] = pend_dat[i];
        mval[i][pend_idx[i]]  = 1'b1;
      end
      pend[i]   = 1'b0;
      bfrom[i]  = -10;
      bto[i]    = -10;
      mdbo[i]   = 8'h00;
      mdbo_k[i] = 1'b1;
    end
    for (int j = sbq.size() - 1; j >= 0; j--)
      if (sbq[j].cyc > edge_n) sbq.delete(j);
    @(posedge clk);
    edge_n++;
    @(negedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) free_at[i] = edge_n + 1;
  endtask

  task automatic check_inst(input int i);
    int     f;
    bit     exp_busy;
    entry_t en;
    f = -1;
    exp_busy = (edge_n >= bfrom[i]) && (edge_n <= bto[i]);
    cmp8(i, "busy", {7'b0, busy_a[i]}, {7'b0, exp_busy});
    for (int j = 0; j < sbq.size(); j++) begin
      if (sbq[j].inst == i) begin
        f = j;
        break;
      end
    end
    if (rdy_a[i] === 1'b1) begin
      if (f < 0) begin
        vec++;
        miss++;
        $display("FAIL spurious_rdy inst%0d edge %0d: got rdy 1 expected 0", i, edge_n);
      end else begin
        en = sbq[f];
        sbq.delete(f);
        cmpi(i, "rdy_edge", edge_n, en.cyc);
        cmp8(i, "err", {7'b0, err_a[i]}, {7'b0, en.err});
        if (en.chk) cmp8(i, "dbo", dbo_a[i], en.dbo);
      end
    end else if (rdy_a[i] !== 1'b0) begin
      vec++;
      miss++;
      $display("FAIL rdy_x inst%0d edge %0d: got %b expected 0/1", i, edge_n, rdy_a[i]);
    end else if (f >= 0 && sbq[f].cyc <= edge_n) begin
      vec++;
      miss++;
      $display("FAIL missing_rdy inst%0d edge %0d: got rdy 0 expected 1 at edge %0d", i, edge_n, sbq[f].cyc);
      sbq.delete(f);
    end
  endtask

  // Monitor: checks every instance once per cycle on the falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) check_inst(i);
  end

  initial begin
    logic [15:0] a;
    int          sel;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < SPAN; k++) mval[i][k] = 1'b0;
      mdbo[i] = 8'h00; mdbo_k[i] = 1'b1;
      free_at[i] = 0; bfrom[i] = -10; bto[i] = -10; pend[i] = 1'b0;
      pend_done[i] = 0; pend_idx[i] = 8'h00; pend_dat[i] = 8'h00;
    end
    @(negedge clk);
    #1;
    do_reset();

    // Write and read back with wait states.
    step(1'b1, 16'h4010, 8'hA5, 1'b1); idle(4);
    step(1'b1, 16'h4010, 8'h00, 1'b0); idle(4);
    // Misses just below and just above the window.
    step(1'b1, 16'h3FFF, 8'h12, 1'b0); idle(1);
    step(1'b1, 16'h4100, 8'h34, 1'b0); idle(1);
    // Back-to-back on the zero-wait instance: read issued on the rdy cycle.
    step(1'b1, 16'h40FF, 8'h3C, 1'b1);
    step(1'b0, 16'h40FF, 8'h00, 1'b0);
    step(1'b1, 16'h40FF, 8'h00, 1'b0); idle(4);
    // Reset in the middle of a pending write.
    step(1'b1, 16'h4020, 8'h11, 1'b1); idle(4);
    step(1'b1, 16'h4020, 8'h22, 1'b1);
    step(1'b0, 16'h4020, 8'h22, 1'b1);
    do_reset();
    step(1'b1, 16'h4020, 8'h00, 1'b0); idle(4);
    // req held high with a changing address while busy.
    step(1'b1, 16'h4030, 8'h77, 1'b1);
    for (int k = 0; k < 5; k++)
      step(1'b1, 16'h4000 + 16'($urandom_range(0, 255)), 8'($urandom), 1'($urandom));
    idle(4);
    step(1'b1, 16'h4030, 8'h00, 1'b0); idle(4);

    // Random traffic.
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else begin
        sel = int'($urandom_range(0, 9));
        case (sel)
          0:       a = 16'h3FFF;
          1:       a = 16'($urandom_range(0, 'h3FFF));
          2:       a = 16'($urandom_range('h4100, 'hFFFF));
          3:       a = 16'h40FF;
          default: a = 16'h4000 + 16'($urandom_range(0, 15));
        endcase
        step(1'($urandom_range(0, 9) < 7), a, 8'($urandom), 1'($urandom));
      end
    end
    idle(10);

    vec++;
    if (sbq.size() != 0) begin
      miss++;
      $display("FAIL leftover: got %0d pending responses expected 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
